// File: rtl/ram_loader_pkg.sv
// Shared types for the source-RAM stream loader.
// Modes, FSM states and the source read latency.
package ram_loader_pkg;

   typedef enum logic [1:0] {
      LD_PIX   = 2'd0,
      LD_WEI   = 2'd1,
      LD_DENSE = 2'd2
   } ld_mode_e;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      DONE
   } ld_state_e;

   localparam int RAM_LAT = 1;

   // Reserved code 3 falls back to the pixel path.
   function automatic logic is_pack(
      input logic [1:0] m
   );
      return (m == LD_WEI) || (m == LD_DENSE);
   endfunction

endpackage

// File: rtl/ram_stream_loader_if.sv
// Control, source-RAM and destination-memory bundle
// between the layer sequencer side and the loader.
interface ram_stream_loader_if #(
   parameter int DATA_W  = 8,
   parameter int PACK    = 9,
   parameter int SRC_AW  = 13,
   parameter int PIX_AW  = 13,
   parameter int WEI_AW  = 11,
   parameter int DENSE_W = 5
);
   logic                   start;
   logic [1:0]             mode;
   logic [SRC_AW-1:0]      src_first;
   logic [SRC_AW-1:0]      src_last;
   logic [DENSE_W-1:0]     dense_len;
   logic [SRC_AW-1:0]      ram_addr;
   logic                   ram_re;
   logic [DATA_W-1:0]      ram_data;
   logic                   pix_we;
   logic [PIX_AW-1:0]      pix_addr;
   logic [DATA_W-1:0]      pix_data;
   logic                   wei_we;
   logic [WEI_AW-1:0]      wei_addr;
   logic [DATA_W*PACK-1:0] wei_data;
   logic                   busy;
   logic                   done;

   modport master (
      output start, mode, src_first, src_last,
      output dense_len, ram_data,
      input  ram_addr, ram_re,
      input  pix_we, pix_addr, pix_data,
      input  wei_we, wei_addr, wei_data,
      input  busy, done
   );

   modport slave (
      input  start, mode, src_first, src_last,
      input  dense_len, ram_data,
      output ram_addr, ram_re,
      output pix_we, pix_addr, pix_data,
      output wei_we, wei_addr, wei_data,
      output busy, done
   );
endinterface

// File: rtl/ram_stream_loader_weight_packer.sv
// Packs source words MSB-first into one weight word,
// with optional row flush and end-of-transfer flush.
module weight_packer
   import ram_loader_pkg::*;
#(
   parameter int PACK    = 9,
   parameter int DATA_W  = 8,
   parameter int DENSE_W = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear_i,
   input  logic                   push_i,
   input  logic [DATA_W-1:0]      data_i,
   input  logic                   flush_i,
   input  logic [DENSE_W-1:0]     dense_len_i,
   output logic                   wr_o,
   output logic [DATA_W*PACK-1:0] word_o
);
   localparam int SW = $clog2(PACK);
   localparam int W  = DATA_W * PACK;

   logic [SW-1:0]      slot_q;
   logic [W-1:0]       buf_q;
   logic [W-1:0]       word_q;
   logic [W-1:0]       merged;
   logic [DENSE_W-1:0] row_q;
   logic               wr_q;
   logic               wr_d;
   logic               hit_full;
   logic               hit_row;

   always_comb begin
      merged = buf_q;
      for (int i = 0; i < PACK; i++) begin
         if (slot_q == SW'(i))
            merged[DATA_W*(PACK-i)-1 -: DATA_W] = data_i;
      end
   end

   assign hit_full = (slot_q == SW'(PACK - 1));
   assign hit_row  = (dense_len_i != '0) &&
                     (row_q == dense_len_i - 1'b1);

   // Full word, row end and final flush collapse
   // into a single write.
   assign wr_d = (push_i && (hit_full || hit_row)) ||
                 (flush_i && (push_i || slot_q != '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q <= '0;
         buf_q  <= '0;
         word_q <= '0;
         row_q  <= '0;
         wr_q   <= 1'b0;
      end else if (clear_i) begin
         slot_q <= '0;
         buf_q  <= '0;
         row_q  <= '0;
         wr_q   <= 1'b0;
      end else begin
         wr_q <= wr_d;
         if (wr_d) begin
            word_q <= push_i ? merged : buf_q;
            buf_q  <= '0;
            slot_q <= '0;
         end else if (push_i) begin
            buf_q  <= merged;
            slot_q <= slot_q + 1'b1;
         end
         if (push_i)
            row_q <= hit_row ? '0 : row_q + 1'b1;
      end
   end

   assign wr_o   = wr_q;
   assign word_o = word_q;

endmodule

// File: rtl/ram_stream_loader.sv
// Copies one source-RAM segment into pixel memory,
// or packs it into weight memory (WEI / DENSE).
module ram_stream_loader
   import ram_loader_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int PACK    = 9,
   parameter int SRC_AW  = 13,
   parameter int PIX_AW  = 13,
   parameter int WEI_AW  = 11,
   parameter int DENSE_W = 5
) (
   input logic               clk,
   input logic               rst_n,
   ram_stream_loader_if.slave bus
);
   ld_state_e              state_q;
   ld_state_e              state_d;
   logic [1:0]             mode_q;
   logic [SRC_AW-1:0]      addr_q;
   logic [SRC_AW-1:0]      last_q;
   logic [DENSE_W-1:0]     dlen_q;
   logic                   re_q;
   logic                   busy_q;
   logic                   done_q;
   logic [RAM_LAT-1:0]     rpipe_q;
   logic                   pix_we_q;
   logic [PIX_AW-1:0]      pix_cnt_q;
   logic [PIX_AW-1:0]      pix_addr_q;
   logic [DATA_W-1:0]      pix_data_q;
   logic [WEI_AW-1:0]      wei_cnt_q;
   logic                   pk_wr;
   logic [DATA_W*PACK-1:0] pk_word;
   logic                   go;
   logic                   empty;
   logic                   cap_v;
   logic                   pix_m;

   assign go    = (state_q == IDLE) && bus.start;
   assign empty = bus.src_last < bus.src_first;
   assign cap_v = rpipe_q[RAM_LAT-1];
   assign pix_m = !is_pack(mode_q);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (bus.start) state_d = empty ? DONE : READ;
         READ:  if (addr_q == last_q) state_d = DRAIN;
         DRAIN: state_d = DONE;
         DONE:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         mode_q     <= '0;
         addr_q     <= '0;
         last_q     <= '0;
         dlen_q     <= '0;
         re_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rpipe_q    <= '0;
         pix_we_q   <= 1'b0;
         pix_cnt_q  <= '0;
         pix_addr_q <= '0;
         pix_data_q <= '0;
         wei_cnt_q  <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == DONE);
         rpipe_q <= (rpipe_q << 1) | RAM_LAT'(re_q);
         if (go) begin
            mode_q    <= bus.mode;
            last_q    <= bus.src_last;
            dlen_q    <= bus.dense_len;
            addr_q    <= bus.src_first;
            re_q      <= !empty;
            busy_q    <= 1'b1;
            pix_cnt_q <= '0;
         end else if (state_q == READ) begin
            if (addr_q == last_q) re_q <= 1'b0;
            else addr_q <= addr_q + 1'b1;
         end
         if (state_q == DONE) busy_q <= 1'b0;
         // Captured word is registered once more on its
         // way to the pixel memory.
         pix_we_q <= cap_v && pix_m;
         if (cap_v && pix_m) begin
            pix_data_q <= bus.ram_data;
            pix_addr_q <= pix_cnt_q;
            pix_cnt_q  <= pix_cnt_q + 1'b1;
         end
         if (go) wei_cnt_q <= '0;
         else if (pk_wr) wei_cnt_q <= wei_cnt_q + 1'b1;
      end
   end

   weight_packer #(
      .PACK    (PACK),
      .DATA_W  (DATA_W),
      .DENSE_W (DENSE_W)
   ) u_pack (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_i     (go),
      .push_i      (cap_v && !pix_m),
      .data_i      (bus.ram_data),
      .flush_i     ((state_q == DRAIN) && !pix_m),
      .dense_len_i ((mode_q == LD_DENSE) ? dlen_q : '0),
      .wr_o        (pk_wr),
      .word_o      (pk_word)
   );

   assign bus.ram_addr = addr_q;
   assign bus.ram_re   = re_q;
   assign bus.pix_we   = pix_we_q;
   assign bus.pix_addr = pix_addr_q;
   assign bus.pix_data = pix_data_q;
   assign bus.wei_we   = pk_wr;
   assign bus.wei_addr = wei_cnt_q;
   assign bus.wei_data = pk_word;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_ram_stream_loader.sv
// Directed bench for ram_stream_loader: pixel copy,
// weight packing, dense flush, reset and start corner cases.
module tb_ram_stream_loader;
   import ram_loader_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ram_stream_loader_if bus ();

   ram_stream_loader dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [7:0]  mem [0:8191];
   logic [7:0]  pix_d [$];
   int          pix_a [$];
   logic [71:0] wei_d [$];
   int          wei_a [$];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int t0 = 0;
   int done_cyc = 0;
   int done_seen = 0;
   int both = 0;
   int pb = 0;
   int wb = 0;
   int db = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.ram_re) bus.ram_data <= mem[bus.ram_addr];
   end

   always @(negedge clk) begin
      if (bus.pix_we) begin
         pix_d.push_back(bus.pix_data);
         pix_a.push_back(int'(bus.pix_addr));
      end
      if (bus.wei_we) begin
         wei_d.push_back(bus.wei_data);
         wei_a.push_back(int'(bus.wei_addr));
      end
      if (bus.pix_we && bus.wei_we) both++;
      if (bus.done) begin
         done_seen++;
         done_cyc = cyc;
      end
   end

   function automatic logic [71:0] pk(input int base, input int cnt);
      logic [71:0] w;
      w = '0;
      for (int i = 0; i < cnt; i++) w[71-8*i -: 8] = 8'(base + i);
      return w;
   endfunction

   task automatic kick(input logic [1:0] m, input int f,
                       input int l, input int d);
      pb = pix_d.size();
      wb = wei_d.size();
      db = done_seen;
      @(negedge clk);
      bus.mode = m;
      bus.src_first = 13'(f);
      bus.src_last = 13'(l);
      bus.dense_len = 5'(d);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      t0 = cyc;
   endtask

   task automatic wait_done(output int dc);
      dc = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done_seen > db) begin
            dc = done_cyc - t0 + 1;
            break;
         end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus.ram_re, bus.ram_addr, bus.pix_we, bus.wei_we,
           bus.busy, bus.done} !== '0) begin
         bad++;
         $display("FAIL reset_ctl got=%h want=0",
                  {bus.ram_re, bus.ram_addr, bus.pix_we,
                   bus.wei_we, bus.busy, bus.done});
      end
      total++;
      if ({bus.pix_addr, bus.pix_data, bus.wei_addr,
           bus.wei_data} !== '0) begin
         bad++;
         $display("FAIL reset_data got=%h want=0",
                  {bus.pix_addr, bus.pix_data, bus.wei_addr,
                   bus.wei_data});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_pix();
      int dc;
      for (int i = 0; i < 4; i++) mem[10+i] = 8'(i + 1);
      kick(2'd0, 10, 13, 0);
      total++;
      if ({bus.busy, bus.ram_re, bus.ram_addr} !== {2'b11, 13'd10}) begin
         bad++;
         $display("FAIL pix_cycle1 got=%h want=%h",
                  {bus.busy, bus.ram_re, bus.ram_addr}, {2'b11, 13'd10});
      end
      wait_done(dc);
      total++;
      if (dc !== 7) begin
         bad++;
         $display("FAIL pix_done_cycle got=%0d want=7", dc);
      end
      total++;
      if (pix_d.size() - pb !== 4 || wei_d.size() - wb !== 0) begin
         bad++;
         $display("FAIL pix_count got=%0d/%0d want=4/0",
                  pix_d.size() - pb, wei_d.size() - wb);
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (pb + i >= pix_d.size() || pix_a[pb+i] !== i ||
             pix_d[pb+i] !== 8'(i + 1)) begin
            bad++;
            $display("FAIL pix_word%0d got=%0d:%0d want=%0d:%0d", i,
                     (pb + i < pix_a.size()) ? pix_a[pb+i] : -1,
                     (pb + i < pix_d.size()) ? pix_d[pb+i] : 8'hxx,
                     i, i + 1);
         end
      end
      total++;
      if (bus.busy !== 1'b0 || done_seen - db !== 1) begin
         bad++;
         $display("FAIL pix_end got=busy%0b done%0d want=busy0 done1",
                  bus.busy, done_seen - db);
      end
   endtask

   task automatic test_wei_full();
      int dc;
      for (int i = 0; i < 18; i++) mem[100+i] = 8'(i + 1);
      kick(2'd1, 100, 117, 0);
      wait_done(dc);
      total++;
      if (dc !== 21) begin
         bad++;
         $display("FAIL wei_full_done got=%0d want=21", dc);
      end
      total++;
      if (wei_d.size() - wb !== 2 || pix_d.size() - pb !== 0) begin
         bad++;
         $display("FAIL wei_full_count got=%0d/%0d want=2/0",
                  wei_d.size() - wb, pix_d.size() - pb);
      end
      for (int i = 0; i < 2; i++) begin
         total++;
         if (wb + i >= wei_d.size() || wei_a[wb+i] !== i ||
             wei_d[wb+i] !== pk(1 + 9 * i, 9)) begin
            bad++;
            $display("FAIL wei_full_word%0d got=%h want=%h", i,
                     (wb + i < wei_d.size()) ? wei_d[wb+i] : 72'hx,
                     pk(1 + 9 * i, 9));
         end
      end
   endtask

   task automatic test_wei_partial();
      int dc;
      for (int i = 0; i < 10; i++) mem[200+i] = 8'(i + 1);
      kick(2'd1, 200, 209, 0);
      wait_done(dc);
      total++;
      if (dc !== 13 || wei_d.size() - wb !== 2) begin
         bad++;
         $display("FAIL wei_part_count got=%0d/%0d want=13/2",
                  dc, wei_d.size() - wb);
      end
      total++;
      if (wb >= wei_d.size() || wei_d[wb] !== pk(1, 9)) begin
         bad++;
         $display("FAIL wei_part_word0 got=%h want=%h",
                  (wb < wei_d.size()) ? wei_d[wb] : 72'hx, pk(1, 9));
      end
      total++;
      if (wb + 1 >= wei_d.size() || wei_a[wb+1] !== 1 ||
          wei_d[wb+1] !== pk(10, 1)) begin
         bad++;
         $display("FAIL wei_part_word1 got=%h want=%h",
                  (wb + 1 < wei_d.size()) ? wei_d[wb+1] : 72'hx,
                  pk(10, 1));
      end
   endtask

   task automatic test_dense();
      int dc;
      logic [71:0] exp_w [3];
      exp_w[0] = pk(1, 4);
      exp_w[1] = pk(5, 4);
      exp_w[2] = pk(9, 1);
      for (int i = 0; i < 9; i++) mem[300+i] = 8'(i + 1);
      kick(2'd2, 300, 308, 4);
      wait_done(dc);
      total++;
      if (dc !== 12 || wei_d.size() - wb !== 3) begin
         bad++;
         $display("FAIL dense_count got=%0d/%0d want=12/3",
                  dc, wei_d.size() - wb);
      end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (wb + i >= wei_d.size() || wei_a[wb+i] !== i ||
             wei_d[wb+i] !== exp_w[i]) begin
            bad++;
            $display("FAIL dense_word%0d got=%h want=%h", i,
                     (wb + i < wei_d.size()) ? wei_d[wb+i] : 72'hx,
                     exp_w[i]);
         end
      end
   endtask

   task automatic test_mode3();
      int dc;
      kick(2'd3, 10, 13, 0);
      wait_done(dc);
      total++;
      if (dc !== 7 || pix_d.size() - pb !== 4 ||
          wei_d.size() - wb !== 0) begin
         bad++;
         $display("FAIL mode3_count got=%0d/%0d/%0d want=7/4/0", dc,
                  pix_d.size() - pb, wei_d.size() - wb);
      end
      total++;
      if (pb + 3 >= pix_d.size() || pix_d[pb+3] !== 8'd4) begin
         bad++;
         $display("FAIL mode3_last got=%h want=04",
                  (pb + 3 < pix_d.size()) ? pix_d[pb+3] : 8'hxx);
      end
   endtask

   task automatic test_reset_mid();
      kick(2'd1, 100, 117, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus.ram_re, bus.ram_addr, bus.busy, bus.done,
           bus.pix_we, bus.wei_we, bus.wei_data} !== '0) begin
         bad++;
         $display("FAIL mid_reset got=%h want=0",
                  {bus.ram_re, bus.ram_addr, bus.busy, bus.done,
                   bus.pix_we, bus.wei_we, bus.wei_data});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (done_seen !== db || wei_d.size() !== wb || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL mid_abort got=done%0d wr%0d busy%0b want=0/0/0",
                  done_seen - db, wei_d.size() - wb, bus.busy);
      end
      test_wei_full();
   endtask

   task automatic test_back_to_back();
      int dc;
      kick(2'd0, 10, 13, 0);
      bus.mode = 2'd1;
      bus.src_first = 13'd100;
      bus.src_last = 13'd117;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(dc);
      total++;
      if (dc !== 7 || pix_d.size() - pb !== 4 ||
          wei_d.size() - wb !== 0 || done_seen - db !== 1) begin
         bad++;
         $display("FAIL busy_start got=%0d/%0d/%0d/%0d want=7/4/0/1", dc,
                  pix_d.size() - pb, wei_d.size() - wb, done_seen - db);
      end
      kick(2'd0, 20, 19, 0);
      total++;
      if ({bus.busy, bus.ram_re} !== 2'b10) begin
         bad++;
         $display("FAIL empty_cycle1 got=%b want=10",
                  {bus.busy, bus.ram_re});
      end
      wait_done(dc);
      total++;
      if (dc !== 2 || pix_d.size() - pb !== 0 ||
          wei_d.size() - wb !== 0) begin
         bad++;
         $display("FAIL empty_run got=%0d/%0d/%0d want=2/0/0", dc,
                  pix_d.size() - pb, wei_d.size() - wb);
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.mode = 2'd0;
      bus.src_first = '0;
      bus.src_last = '0;
      bus.dense_len = '0;
      test_reset();
      test_pix();
      test_wei_full();
      test_wei_partial();
      test_dense();
      test_mode3();
      test_reset_mid();
      test_back_to_back();
      total++;
      if (both !== 0) begin
         bad++;
         $display("FAIL strobe_overlap got=%0d want=0", both);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
